// File: rtl/pentary_mem_pkg.sv
// Shared constants, FSM state type and beat helpers for the L2 line responder.
package pentary_mem_pkg;

    localparam int LINE_BITS     = 512;
    localparam int BEAT_WIDTH    = 64;
    localparam int BEATS         = LINE_BITS / BEAT_WIDTH;
    localparam int LINE_OFFSET_W = 6;
    localparam int BEAT_IDX_W    = 3;
    localparam int CNT_W         = 4;

    // Counter constants sized to the 4-bit issue/return counters.
    localparam logic [CNT_W-1:0] BEAT_COUNT = 4'd8;
    localparam logic [CNT_W-1:0] BEAT_LAST  = 4'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } resp_state_t;

    // Byte address of one beat: line base with the beat index in bits [5:3].
    function automatic logic [63:0] beat_addr(input logic [63:0] line_addr,
                                              input logic [BEAT_IDX_W-1:0] beat);
        return (line_addr & ~64'h3F) | {58'd0, beat, 3'b000};
    endfunction

    // Beat k of a line lives in bits [64k+63:64k].
    function automatic logic [BEAT_WIDTH-1:0] get_beat(input logic [LINE_BITS-1:0] line,
                                                       input logic [BEAT_IDX_W-1:0] idx);
        return line[idx*BEAT_WIDTH +: BEAT_WIDTH];
    endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// L2 line port plus narrow backing-memory beat port.
//
// Handshakes:
//   L2 side: mem_read/mem_write are level-held requests; mem_ready is a
//   one-cycle completion pulse, after which L2 drops or changes the request.
//   Backing side: a beat transfers on a rising edge where bk_req & bk_gnt;
//   while bk_req is high and bk_gnt low, bk_addr/bk_we/bk_wdata hold. Read
//   data returns in issue order as bk_rvalid/bk_rdata, no earlier than the
//   cycle after the grant.
interface l2_mem_responder_if #(parameter int ADDR_WIDTH = 48);
    import pentary_mem_pkg::*;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [LINE_BITS-1:0]  mem_write_data;
    logic [LINE_BITS-1:0]  mem_read_data;
    logic                  mem_ready;

    logic [ADDR_WIDTH-1:0] bk_addr;
    logic                  bk_req;
    logic                  bk_we;
    logic [BEAT_WIDTH-1:0] bk_wdata;
    logic                  bk_gnt;
    logic [BEAT_WIDTH-1:0] bk_rdata;
    logic                  bk_rvalid;

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_write_data,
        input  bk_gnt, bk_rdata, bk_rvalid,
        output mem_read_data, mem_ready,
        output bk_addr, bk_req, bk_we, bk_wdata
    );

    modport master (
        output mem_addr, mem_read, mem_write, mem_write_data,
        output bk_gnt, bk_rdata, bk_rvalid,
        input  mem_read_data, mem_ready,
        input  bk_addr, bk_req, bk_we, bk_wdata
    );

endinterface

// File: rtl/mem_line_buffer.sv
// One cache line of storage: whole-line load or single beat write by index.
module mem_line_buffer
    import pentary_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [LINE_BITS-1:0]  load_line,
    input  logic                  beat_we,
    input  logic [BEAT_IDX_W-1:0] beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_wdata,
    output logic [LINE_BITS-1:0]  line
);

    logic [LINE_BITS-1:0] line_q, line_d;

    // Next line contents: full load has priority over a beat write.
    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_line;
        end else if (beat_we) begin
            line_d[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = beat_wdata;
        end
    end

    // Line storage register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/l2_mem_responder.sv
// Turns one 512-bit L2 line read/writeback into an 8-beat 64-bit burst.
module l2_mem_responder
    import pentary_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 48
) (
    input  logic                clk,
    input  logic                reset,
    l2_mem_responder_if.slave   bus,
    output resp_state_t         dbg_state
);

    resp_state_t           state_q, state_d;
    logic [CNT_W-1:0]      iss_q, iss_d;
    logic [CNT_W-1:0]      ret_q, ret_d;
    logic [ADDR_WIDTH-1:0] line_q, line_d;

    logic                  wbuf_load;
    logic                  rbuf_we;
    logic [LINE_BITS-1:0]  wbuf_line;
    logic [LINE_BITS-1:0]  rbuf_line;

    logic                  bk_req;
    logic                  bk_we;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] bk_addr;
    logic [BEAT_WIDTH-1:0] bk_wdata;
    logic [ADDR_WIDTH-1:0] cur_beat_addr;

    // Writeback data latch, loaded once when a write is accepted.
    mem_line_buffer u_wbuf (
        .clk        (clk),
        .rst_n      (reset),
        .load_en    (wbuf_load),
        .load_line  (bus.mem_write_data),
        .beat_we    (1'b0),
        .beat_idx   (iss_q[BEAT_IDX_W-1:0]),
        .beat_wdata (bus.bk_rdata),
        .line       (wbuf_line)
    );

    // Read assembly; holds the last fill until the next read overwrites it.
    mem_line_buffer u_rbuf (
        .clk        (clk),
        .rst_n      (reset),
        .load_en    (1'b0),
        .load_line  (bus.mem_write_data),
        .beat_we    (rbuf_we),
        .beat_idx   (ret_q[BEAT_IDX_W-1:0]),
        .beat_wdata (bus.bk_rdata),
        .line       (rbuf_line)
    );

    // State, counters and latched line address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            iss_q   <= '0;
            ret_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            line_q  <= line_d;
        end
    end

    // Next state: request acceptance, grant/return counting, burst completion.
    always_comb begin
        state_d   = state_q;
        iss_d     = iss_q;
        ret_d     = ret_q;
        line_d    = line_q;
        wbuf_load = 1'b0;
        rbuf_we   = 1'b0;
        case (state_q)
            IDLE: begin
                iss_d = '0;
                ret_d = '0;
                // Writeback wins over a simultaneous read.
                if (bus.mem_write) begin
                    line_d    = bus.mem_addr & ~ADDR_WIDTH'(63);
                    wbuf_load = 1'b1;
                    state_d   = WR_BURST;
                end else if (bus.mem_read) begin
                    line_d  = bus.mem_addr & ~ADDR_WIDTH'(63);
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if ((iss_q < BEAT_COUNT) && bus.bk_gnt) begin
                    iss_d = iss_q + 4'd1;
                end
                // The 8th return leaves this state, so ret_q never exceeds 7 here.
                if (bus.bk_rvalid) begin
                    rbuf_we = 1'b1;
                    ret_d   = ret_q + 4'd1;
                    if (ret_q == BEAT_LAST) begin
                        state_d = RESP;
                    end
                end
            end
            WR_BURST: begin
                if (bus.bk_gnt) begin
                    iss_d = iss_q + 4'd1;
                    if (iss_q == BEAT_LAST) begin
                        state_d = RESP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cur_beat_addr = ADDR_WIDTH'(beat_addr(64'(line_q), iss_q[BEAT_IDX_W-1:0]));

    // Outputs decoded from state; backing port idles at zero outside bursts.
    always_comb begin
        bk_req    = 1'b0;
        bk_we     = 1'b0;
        bk_addr   = '0;
        bk_wdata  = '0;
        mem_ready = 1'b0;
        case (state_q)
            RD_BURST: begin
                bk_req  = (iss_q < BEAT_COUNT);
                bk_addr = cur_beat_addr;
            end
            WR_BURST: begin
                bk_req   = 1'b1;
                bk_we    = 1'b1;
                bk_addr  = cur_beat_addr;
                bk_wdata = get_beat(wbuf_line, iss_q[BEAT_IDX_W-1:0]);
            end
            RESP: begin
                mem_ready = 1'b1;
            end
            default: begin
                bk_req = 1'b0;
            end
        endcase
    end

    assign bus.bk_req        = bk_req;
    assign bus.bk_we         = bk_we;
    assign bus.bk_addr       = bk_addr;
    assign bus.bk_wdata      = bk_wdata;
    assign bus.mem_ready     = mem_ready;
    assign bus.mem_read_data = rbuf_line;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder with a behavioural backing memory.
module tb_l2_mem_responder;
    import pentary_mem_pkg::*;

    localparam int AW = 48;

    logic        clk = 1'b0;
    logic        reset;
    resp_state_t dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Backing model controls and logs.
    int          gnt_mode  = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          data_mode = 0;
    logic [31:0] salt      = 32'h0;
    longint      cyc       = 0;
    longint      last_due  = 0;
    logic [AW-1:0] pend_addr_q[$];
    longint        pend_due_q[$];
    logic [AW-1:0] gaddr_q[$];
    logic [63:0]   gdata_q[$];
    logic          gwe_q[$];
    logic [63:0]   exp_q[$];

    always #5 clk = ~clk;

    l2_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

    l2_mem_responder #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    function automatic logic [63:0] bk_data(input logic [AW-1:0] a);
        if (data_mode == 0) return (64'(a[5:3]) + 64'd1) * 64'h1111_1111_1111_1111;
        return {a[31:0] ^ salt, ~a[31:0] + salt};
    endfunction

    function automatic logic [511:0] exp_line(input logic [AW-1:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = bk_data(base + AW'(8 * k));
        return l;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_model();
        pend_addr_q.delete();
        pend_due_q.delete();
        gaddr_q.delete();
        gdata_q.delete();
        gwe_q.delete();
        exp_q.delete();
        last_due = 0;
    endtask

    // Backing memory: grants, in-order returns after lat cycles, grant log.
    initial begin
        longint due;
        bus.bk_gnt    = 1'b0;
        bus.bk_rvalid = 1'b0;
        bus.bk_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_due_q.size() > 0 && pend_due_q[0] == cyc) begin
                bus.bk_rvalid = 1'b1;
                bus.bk_rdata  = bk_data(pend_addr_q[0]);
                void'(pend_due_q.pop_front());
                void'(pend_addr_q.pop_front());
            end else begin
                bus.bk_rvalid = 1'b0;
                bus.bk_rdata  = '0;
            end
            bus.bk_gnt = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (bus.bk_req && bus.bk_gnt && reset) begin
                gaddr_q.push_back(bus.bk_addr);
                gdata_q.push_back(bus.bk_wdata);
                gwe_q.push_back(bus.bk_we);
                if (!bus.bk_we) begin
                    due = cyc + longint'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_due_q.push_back(due);
                    pend_addr_q.push_back(bus.bk_addr);
                end
            end
        end
    end

    initial begin
        logic [AW-1:0]  base;
        logic [511:0]   rd_line_exp;
        logic [511:0]   wd;
        int             waited;
        int             extra;
        int             nwr;

        reset              = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;

        // Reset values.
        tick();
        tick();
        check("rst_state", 512'(dbg_state), 512'(IDLE));
        check("rst_ready", 512'(bus.mem_ready), 512'(1'b0));
        check("rst_req", 512'(bus.bk_req), 512'(1'b0));
        check("rst_addr", 512'(bus.bk_addr), 512'(0));
        check("rst_wdata", 512'(bus.bk_wdata), 512'(0));
        check("rst_rdata", bus.mem_read_data, 512'(0));
        reset = 1'b1;
        tick();

        // Reset in the middle of a read burst; later returns must be ignored.
        clear_model();
        lat_min = 4; lat_max = 4;
        bus.mem_addr = 48'h0000_0000_1000;
        bus.mem_read = 1'b1;
        tick();
        bus.mem_read = 1'b0;
        waited = 0;
        while (gaddr_q.size() < 3 && waited < 20) begin
            tick();
            waited++;
        end
        check("midrst_grants_seen", 512'(gaddr_q.size() >= 3), 512'(1'b1));
        tick();
        reset = 1'b0;
        #1;
        check("midrst_req", 512'(bus.bk_req), 512'(1'b0));
        check("midrst_ready", 512'(bus.mem_ready), 512'(1'b0));
        check("midrst_state", 512'(dbg_state), 512'(IDLE));
        check("midrst_addr", 512'(bus.bk_addr), 512'(0));
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("midrst_stray_rdata", bus.mem_read_data, 512'(0));
        check("midrst_stray_state", 512'(dbg_state), 512'(IDLE));
        clear_model();

        // Read of line 0x1234_5640 with gnt tied high and 1-cycle latency.
        lat_min = 1; lat_max = 1; gnt_mode = 0; data_mode = 0;
        base = 48'h0000_1234_5640;
        rd_line_exp = exp_line(base);
        bus.mem_addr = base;
        bus.mem_read = 1'b1;
        check("rd_accept_state", 512'(dbg_state), 512'(IDLE));
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rd_req_%0d", k), 512'(bus.bk_req), 512'(1'b1));
            check($sformatf("rd_addr_%0d", k), 512'(bus.bk_addr), 512'(base + AW'(8 * (k - 1))));
            check($sformatf("rd_we_%0d", k), 512'(bus.bk_we), 512'(1'b0));
            check($sformatf("rd_noready_%0d", k), 512'(bus.mem_ready), 512'(1'b0));
        end
        tick();
        check("rd_t9_req", 512'(bus.bk_req), 512'(1'b0));
        check("rd_t9_ready", 512'(bus.mem_ready), 512'(1'b0));
        tick();
        check("rd_t10_ready", 512'(bus.mem_ready), 512'(1'b1));
        check("rd_t10_state", 512'(dbg_state), 512'(RESP));
        check("rd_beat0", 512'(bus.mem_read_data[63:0]), 512'(64'h1111_1111_1111_1111));
        check("rd_beat7", 512'(bus.mem_read_data[511:448]), 512'(64'h8888_8888_8888_8888));
        check("rd_line", bus.mem_read_data, rd_line_exp);
        bus.mem_read = 1'b0;
        tick();
        check("rd_t11_ready", 512'(bus.mem_ready), 512'(1'b0));
        check("rd_t11_hold", bus.mem_read_data, rd_line_exp);
        check("rd_t11_state", 512'(dbg_state), 512'(IDLE));

        // Writeback of line 0xABC0, beat k carries value k.
        clear_model();
        wd = '0;
        for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'(k);
        base = 48'h0000_0000_ABC0;
        bus.mem_addr       = base;
        bus.mem_write_data = wd;
        bus.mem_write      = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("wr_req_%0d", k), 512'(bus.bk_req), 512'(1'b1));
            check($sformatf("wr_we_%0d", k), 512'(bus.bk_we), 512'(1'b1));
            check($sformatf("wr_addr_%0d", k), 512'(bus.bk_addr), 512'(base + AW'(8 * (k - 1))));
            check($sformatf("wr_wdata_%0d", k), 512'(bus.bk_wdata), 512'(k - 1));
            check($sformatf("wr_noready_%0d", k), 512'(bus.mem_ready), 512'(1'b0));
        end
        tick();
        check("wr_t9_ready", 512'(bus.mem_ready), 512'(1'b1));
        check("wr_t9_state", 512'(dbg_state), 512'(RESP));
        check("wr_rdata_kept", bus.mem_read_data, rd_line_exp);
        bus.mem_write = 1'b0;
        tick();
        check("wr_t10_ready", 512'(bus.mem_ready), 512'(1'b0));

        // Read with random grant stalls and 1..4 cycle return latency.
        clear_model();
        gnt_mode = 1; lat_min = 1; lat_max = 4; data_mode = 1; salt = 32'h5A5A_1234;
        base = 48'h0000_0000_7700;
        rd_line_exp = exp_line(base);
        bus.mem_addr = base;
        bus.mem_read = 1'b1;
        tick();
        waited = 0;
        while (!bus.mem_ready && waited < 300) begin
            tick();
            waited++;
        end
        check("rnd_ready_seen", 512'(bus.mem_ready), 512'(1'b1));
        bus.mem_read = 1'b0;
        check("rnd_line", bus.mem_read_data, rd_line_exp);
        tick();
        check("rnd_ready_one_cycle", 512'(bus.mem_ready), 512'(1'b0));
        check("rnd_grant_count", 512'(gaddr_q.size()), 512'(8));
        for (int k = 0; k < 8 && k < gaddr_q.size(); k++)
            check($sformatf("rnd_gaddr_%0d", k), 512'(gaddr_q[k]), 512'(base + AW'(8 * k)));

        // Writeback then fetch back to back, L2-style handshake.
        clear_model();
        gnt_mode = 0; lat_min = 1; lat_max = 1; data_mode = 0;
        for (int k = 0; k < 16; k++) wd[32*k +: 32] = $urandom;
        for (int k = 0; k < 8; k++) exp_q.push_back(wd[64*k +: 64]);
        bus.mem_addr       = 48'h0000_0000_2000;
        bus.mem_write_data = wd;
        bus.mem_write      = 1'b1;
        for (int k = 1; k <= 8; k++) tick();
        tick();
        check("b2b_wr_ready_t9", 512'(bus.mem_ready), 512'(1'b1));
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.mem_addr  = 48'h0000_0000_3000;
        rd_line_exp   = exp_line(48'h0000_0000_3000);
        tick();
        check("b2b_t10_state", 512'(dbg_state), 512'(IDLE));
        check("b2b_t10_ready", 512'(bus.mem_ready), 512'(1'b0));
        tick();
        check("b2b_t11_state", 512'(dbg_state), 512'(RD_BURST));
        for (int k = 12; k <= 20; k++) tick();
        check("b2b_rd_ready_t20", 512'(bus.mem_ready), 512'(1'b1));
        check("b2b_rd_line", bus.mem_read_data, rd_line_exp);
        bus.mem_read = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.mem_ready) extra++;
        end
        check("b2b_no_dup_ready", 512'(extra), 512'(0));
        check("b2b_final_state", 512'(dbg_state), 512'(IDLE));
        nwr = 0;
        for (int i = 0; i < gaddr_q.size(); i++) begin
            if (gwe_q[i]) begin
                nwr++;
                if (exp_q.size() > 0)
                    check($sformatf("b2b_wdata_%0d", nwr - 1), 512'(gdata_q[i]), 512'(exp_q.pop_front()));
            end
        end
        check("b2b_wr_beats", 512'(nwr), 512'(8));
        check("b2b_total_beats", 512'(gaddr_q.size()), 512'(16));

        // Read and write together, unaligned address: write wins at line base.
        clear_model();
        bus.mem_addr       = 48'h0000_0005_003F;
        bus.mem_write_data = {8{64'hCAFE_F00D_0000_0001}};
        bus.mem_read       = 1'b1;
        bus.mem_write      = 1'b1;
        tick();
        check("both_state", 512'(dbg_state), 512'(WR_BURST));
        check("both_we", 512'(bus.bk_we), 512'(1'b1));
        check("both_addr0", 512'(bus.bk_addr), 512'(48'h0000_0005_0000));
        waited = 0;
        while (!bus.mem_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("both_ready", 512'(bus.mem_ready), 512'(1'b1));
        check("both_rdata_kept", bus.mem_read_data, rd_line_exp);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        tick();
        check("both_idle", 512'(dbg_state), 512'(IDLE));
        check("both_no_read_issued", 512'(pend_due_q.size()), 512'(0));
        check("both_grants", 512'(gaddr_q.size()), 512'(8));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
